// File: rtl/qdiv_pkg.sv
// -----------------------------------------------------------------------------
// qdiv_pkg -- shared definitions for the signed fixed-point divider.
//
// Contents:
//   QDIV_N, QDIV_Q          default word width and fractional bit count (Q8.8)
//   qdiv_state_e            divider FSM states (IDLE, RUN, DONE)
//   QDIV_SAT_POS/NEG        saturation values at the default word width
// -----------------------------------------------------------------------------
package qdiv_pkg;

  localparam int QDIV_N = 16;
  localparam int QDIV_Q = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } qdiv_state_e;

  // Largest positive and most negative representable words at the default width.
  localparam logic [QDIV_N-1:0] QDIV_SAT_POS = {1'b0, {(QDIV_N-1){1'b1}}};
  localparam logic [QDIV_N-1:0] QDIV_SAT_NEG = {1'b1, {(QDIV_N-1){1'b0}}};

endpackage

// File: rtl/qdiv.sv
// -----------------------------------------------------------------------------
// qdiv -- signed two's-complement fixed-point divider (QN-Q.Q format).
//
// Computes (|dividend| << Q) / |divisor| with a restoring shift-subtract loop,
// one quotient bit per clock, MSB first, then applies the sign and saturates.
// The result appears exactly N+Q-1 rising edges after the start-capture edge.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_start         start request; captures operands in any state (restarts RUN)
//   i_dividend      signed fixed-point dividend, N bits
//   i_divisor       signed fixed-point divisor, N bits
//   o_quotient_out  signed quotient, same format; held between results
//   o_complete      high from the final edge until the next start or reset
//   o_overflow      result not representable or divisor zero (saturated output)
//
// Handshake: i_start is a single-cycle request with no ready; a start while a
// division is in flight abandons it. o_complete is a level, not a pulse: it is
// valid whenever high and remains high (with o_quotient_out/o_overflow stable)
// until the next accepted start or reset.
//
// Build option:
//   QDIV_ROUND_EN   round half away from zero instead of truncating.
//
// Debug: the FSM state is the internal signal 'state' (qdiv_state_e), kept
// under that name so checkers can bind to it.
// -----------------------------------------------------------------------------
module qdiv
  import qdiv_pkg::*;
#(
  parameter int N = QDIV_N,
  parameter int Q = QDIV_Q
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient_out,
  output logic         o_complete,
  output logic         o_overflow
);

  // Quotient magnitude width; also the number of iterations.
  localparam int QW = N + Q - 1;
  localparam int CW = $clog2(N + Q);
  localparam logic [CW-1:0] LAST_CNT = CW'(N + Q - 2);

  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};
  // Magnitude limits, widened to hold a rounded quotient magnitude.
  localparam logic [QW:0] MAX_MAG = {{Q{1'b0}}, SAT_POS};
  localparam logic [QW:0] NEG_MAG = {{Q{1'b0}}, SAT_NEG};

  qdiv_state_e   state;
  logic [CW-1:0] cnt;
  logic          sign;      // sign of the result
  logic          dvd_neg;   // dividend sign, selects saturation on divide-by-zero
  logic          hi_ovf;    // quotient bit above the iterated range would be set
  logic [N-1:0]  mag_dvs;   // divisor magnitude
  logic [N-1:0]  rem;       // partial remainder
  logic [QW-1:0] num_quo;   // numerator bits shift out the top, quotient bits in

  // ---------------------------------------------------------------------------
  // Operand magnitudes. Negating -2^(N-1) gives 2^(N-1), which fits N unsigned
  // bits, so the most negative word needs no special handling here.
  // ---------------------------------------------------------------------------
  logic [N-1:0] mag_dvd_in;
  logic [N-1:0] mag_dvs_in;

  always_comb begin
    mag_dvd_in = i_dividend[N-1] ? ({N{1'b0}} - i_dividend) : i_dividend;
    mag_dvs_in = i_divisor[N-1]  ? ({N{1'b0}} - i_divisor)  : i_divisor;
  end

  // ---------------------------------------------------------------------------
  // One restoring step. The numerator (|dividend| << Q) is N+Q bits; its top
  // bit seeds the remainder at capture and the remaining N+Q-1 bits are walked
  // here. Because rem < divisor <= 2^(N-1) holds after every step, the shifted
  // remainder fits N+1 bits.
  // ---------------------------------------------------------------------------
  logic [N:0]    shifted;
  logic          q_bit;
  logic [N-1:0]  rem_next;
  logic [QW-1:0] num_quo_next;
  logic [N:0]    rem_diff;

  always_comb begin
    shifted      = {rem, num_quo[QW-1]};
    q_bit        = (shifted >= {1'b0, mag_dvs});
    rem_diff     = shifted - {1'b0, mag_dvs};
    rem_next     = q_bit ? rem_diff[N-1:0] : shifted[N-1:0];
    num_quo_next = {num_quo[QW-2:0], q_bit};
  end

  // ---------------------------------------------------------------------------
  // Final result, evaluated from the last step's outputs so the quotient is
  // registered on the same edge that completes the iteration.
  // ---------------------------------------------------------------------------
  logic          round_inc;
  logic          div_zero;
  logic [QW:0]   mag_fin;
  logic [N-1:0]  q_fin;
  logic          ovf_fin;

  always_comb begin
`ifdef QDIV_ROUND_EN
    // Round half away from zero: the discarded fraction is >= 1/2 LSB.
    round_inc = ({rem_next, 1'b0} >= {1'b0, mag_dvs});
`else
    round_inc = 1'b0;
`endif
    div_zero = (mag_dvs == {N{1'b0}});
    mag_fin  = {1'b0, num_quo_next} + {{QW{1'b0}}, round_inc};
    q_fin    = {N{1'b0}};
    ovf_fin  = 1'b0;

    if (div_zero) begin
      // Iteration ran on garbage; result depends only on the dividend sign.
      q_fin   = dvd_neg ? SAT_NEG : SAT_POS;
      ovf_fin = 1'b1;
    end else if (hi_ovf) begin
      q_fin   = sign ? SAT_NEG : SAT_POS;
      ovf_fin = 1'b1;
    end else if (sign && (mag_fin == NEG_MAG)) begin
      // -2^(N-1) is representable exactly.
      q_fin   = SAT_NEG;
      ovf_fin = 1'b0;
    end else if (mag_fin > MAX_MAG) begin
      q_fin   = sign ? SAT_NEG : SAT_POS;
      ovf_fin = 1'b1;
    end else begin
      q_fin   = sign ? ({N{1'b0}} - mag_fin[N-1:0]) : mag_fin[N-1:0];
      ovf_fin = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      sign           <= 1'b0;
      dvd_neg        <= 1'b0;
      hi_ovf         <= 1'b0;
      mag_dvs        <= '0;
      rem            <= '0;
      num_quo        <= '0;
      o_quotient_out <= '0;
      o_complete     <= 1'b0;
      o_overflow     <= 1'b0;
    end else if (i_start) begin
      // Start wins in every state, including mid-division.
      state      <= RUN;
      cnt        <= '0;
      sign       <= i_dividend[N-1] ^ i_divisor[N-1];
      dvd_neg    <= i_dividend[N-1];
      mag_dvs    <= mag_dvs_in;
      // Only |dividend| = 2^(N-1) sets the numerator's top bit; with a
      // divisor magnitude of 1 that bit becomes a quotient bit beyond QW.
      hi_ovf     <= mag_dvd_in[N-1] && (mag_dvs_in == {{(N-1){1'b0}}, 1'b1});
      rem        <= {{(N-1){1'b0}}, mag_dvd_in[N-1]};
      num_quo    <= {mag_dvd_in[N-2:0], {Q{1'b0}}};
      o_complete <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        RUN: begin
          rem     <= rem_next;
          num_quo <= num_quo_next;
          cnt     <= cnt + {{(CW-1){1'b0}}, 1'b1};
          if (cnt == LAST_CNT) begin
            state          <= DONE;
            o_quotient_out <= q_fin;
            o_overflow     <= ovf_fin;
            o_complete     <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv.sv
// -----------------------------------------------------------------------------
// tb_qdiv -- self-checking bench for qdiv at default parameters (Q8.8).
// Table vectors, model-checked random vectors, and hand-written reset and
// restart sequences. Expected results go into exp_q when a start is driven
// and are popped when o_complete rises.
// -----------------------------------------------------------------------------
module tb_qdiv;
  import qdiv_pkg::*;

  localparam int N   = QDIV_N;
  localparam int Q   = QDIV_Q;
  localparam int LAT = N + Q - 1;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic         complete;
  logic         overflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  qdiv #(.N(N), .Q(Q)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_dividend     (dividend),
    .i_divisor      (divisor),
    .o_quotient_out (quotient),
    .o_complete     (complete),
    .o_overflow     (overflow)
  );

  // ---------------- scoreboard state ----------------
  logic [N:0]   exp_q[$];   // {overflow, quotient}
  logic [N-1:0] last_q;     // quotient the DUT must hold while not complete
  int           total = 0;
  int           bad   = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic         ovf;
    string        name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [N-1:0] q, input logic ovf, input string name);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.ovf = ovf; v.name = name;
    vecs.push_back(v);
  endfunction

  // Reference: plain integer division of the scaled magnitudes.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    longint av, bv, ma, mb, num, mag, limit, res;
    bit     neg;
`ifdef QDIV_ROUND_EN
    longint rm;
`endif
    if (b == '0) return {1'b1, a[N-1] ? QDIV_SAT_NEG : QDIV_SAT_POS};
    av    = longint'($signed(a));
    bv    = longint'($signed(b));
    ma    = (av < 0) ? -av : av;
    mb    = (bv < 0) ? -bv : bv;
    num   = ma << Q;
    mag   = num / mb;
`ifdef QDIV_ROUND_EN
    rm    = num % mb;
    if (2 * rm >= mb) mag = mag + 1;
`endif
    neg   = a[N-1] ^ b[N-1];
    limit = longint'(1) << (N - 1);
    if (neg && mag == limit) return {1'b0, QDIV_SAT_NEG};
    if (mag > limit - 1) return {1'b1, neg ? QDIV_SAT_NEG : QDIV_SAT_POS};
    res = neg ? -mag : mag;
    return {1'b0, res[N-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at 1 time unit after a rising edge; returns likewise.
  task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N:0] exp);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    chk("complete_cleared_on_start", complete, 0);
    chk("overflow_cleared_on_start", overflow, 0);
  endtask

  task automatic wait_result(input string name);
    int         lat;
    bit         done;
    bit         hold_ok;
    logic [N:0] e;
    lat     = 0;
    done    = 1'b0;
    hold_ok = 1'b1;
    while (!done && lat < LAT + 10) begin
      @(posedge clk); #1;
      lat++;
      if (complete) done = 1'b1;
      else if (quotient !== last_q) hold_ok = 1'b0;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_latency"}, lat, LAT);
    chk({name, "_hold_in_run"}, hold_ok, 1);
    chk({name, "_sb_nonempty"}, (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({name, "_quotient"}, quotient, e[N-1:0]);
      chk({name, "_overflow"}, overflow, e[N]);
      last_q = e[N-1:0];
      repeat (3) begin
        @(posedge clk); #1;
      end
      chk({name, "_held_complete"}, complete, 1);
      chk({name, "_held_quotient"}, quotient, e[N-1:0]);
      chk({name, "_held_overflow"}, overflow, e[N]);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] ra, rb;
    bit           seen;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    last_q   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_quotient", quotient, 0);
    chk("reset_complete", complete, 0);
    chk("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_complete_low", complete, 0);

    //        dividend  divisor   quotient  ovf
    add_vec(16'h0300, 16'h0600, 16'h0080, 1'b0, "pos_half");
    add_vec(16'hFD00, 16'h0600, 16'hFF80, 1'b0, "neg_half");
    add_vec(16'h7F00, 16'h0080, 16'h7FFF, 1'b1, "pos_sat");
    add_vec(16'h8100, 16'h0080, 16'h8000, 1'b1, "neg_sat");
    add_vec(16'h0100, 16'h0000, 16'h7FFF, 1'b1, "divzero_pos");
    add_vec(16'hFF00, 16'h0000, 16'h8000, 1'b1, "divzero_neg");
    add_vec(16'h0000, 16'h0000, 16'h7FFF, 1'b1, "divzero_zero");
    add_vec(16'h0000, 16'h0300, 16'h0000, 1'b0, "zero_dividend");
    add_vec(16'h0100, 16'h0400, 16'h0040, 1'b0, "quarter");
    add_vec(16'h8000, 16'h0100, 16'h8000, 1'b0, "min_div_one");
    add_vec(16'h8000, 16'hFF00, 16'h7FFF, 1'b1, "min_div_neg_one");
    add_vec(16'h8000, 16'h0001, 16'h8000, 1'b1, "min_div_lsb");
    add_vec(16'h0001, 16'h0100, 16'h0001, 1'b0, "lsb_div_one");
    add_vec(16'h0600, 16'hFA00, 16'hFF00, 1'b0, "neg_one");
    add_vec(16'h7FFF, 16'h7FFF, 16'h0100, 1'b0, "max_div_max");
    add_vec(16'h4000, 16'h0200, 16'h2000, 1'b0, "sixtyfour_div_two");
    add_vec(16'h8000, 16'h8000, 16'h0100, 1'b0, "min_div_min");
    add_vec(16'h7F00, 16'h0100, 16'h7F00, 1'b0, "max_int_div_one");
    add_vec(16'hC000, 16'h0080, 16'h8000, 1'b0, "neg_exact_min");
    add_vec(16'h4000, 16'h0080, 16'h7FFF, 1'b1, "pos_just_over");

    foreach (vecs[i]) begin
      drive_start(vecs[i].a, vecs[i].b, {vecs[i].ovf, vecs[i].q});
      wait_result(vecs[i].name);
    end

    // Random operands against the integer model; every fourth divisor small
    // to exercise saturation.
    for (int j = 0; j < 16; j++) begin
      ra = N'($urandom_range(0, 65535));
      rb = (j % 4 == 0) ? N'($urandom_range(1, 255)) : N'($urandom_range(0, 65535));
      drive_start(ra, rb, model(ra, rb));
      wait_result("random");
    end

    // Reset in the middle of a division.
    drive_start(16'h0300, 16'h0600, {1'b0, 16'h0080});
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_quotient", quotient, 0);
    chk("midrun_reset_complete", complete, 0);
    chk("midrun_reset_overflow", overflow, 0);
    exp_q.delete();
    last_q = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (complete) seen = 1'b1;
    end
    chk("no_complete_after_reset", seen, 0);
    chk("quotient_zero_after_reset", quotient, 0);
    drive_start(16'h0300, 16'h0600, {1'b0, 16'h0080});
    wait_result("after_reset");

    // Restart five cycles into a division with new operands.
    drive_start(16'h0300, 16'h0600, {1'b0, 16'h0080});
    repeat (4) @(posedge clk);
    #1;
    exp_q.delete();
    drive_start(16'h0100, 16'h0400, {1'b0, 16'h0040});
    wait_result("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qdiv.md
QDIV -- requirements
Module: qdiv

Interface
REQ-001 Parameter N, default 16: total word width of operands and quotient; signed two's complement.
REQ-002 Parameter Q, default 8: number of fractional bits (Q8.8 format by default).
REQ-003 The block SHALL have one clock and one asynchronous active-low reset; all other ports are listed below, clock and reset first.
REQ-004 i_clk  input  1  clock; all state updates on the rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_start  input  1  start request, sampled on the rising edge.
REQ-007 i_dividend  input  N  signed fixed-point dividend, QN-Q.Q.
REQ-008 i_divisor  input  N  signed fixed-point divisor, QN-Q.Q.
REQ-009 o_quotient_out  output  N  signed two's-complement quotient, same format as the operands.
REQ-010 o_complete  output  1  quotient valid.
REQ-011 o_overflow  output  1  result not representable, or divisor is zero.

Function
REQ-012 The design SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-013 On a rising edge with i_start=1 in any state, the design SHALL capture both operands and enter RUN.
- In that same edge, o_complete and o_overflow are cleared.
- A start received in RUN aborts the current division and restarts it.
REQ-014 On capture, the design SHALL:
- store the sign as dividend sign XOR divisor sign;
- store the operand magnitudes, N bits each, so that -2^(N-1) is handled.
REQ-015 In RUN, the design SHALL perform a restoring shift-subtract division of (|dividend| << Q) by |divisor|.
- One quotient bit is produced per clock, MSB first.
- The quotient magnitude is N+Q-1 bits wide.
REQ-016 Latency: o_complete SHALL rise exactly N+Q-1 rising edges after the start-capture edge (23 at defaults).
- On that edge, o_quotient_out is updated and the FSM enters DONE.
REQ-017 In DONE, o_complete, o_quotient_out and o_overflow SHALL hold their values until the next i_start or reset.
REQ-018 Rounding SHALL truncate the magnitude toward zero, then negate if the stored sign is 1.
REQ-019 Overflow: if the final magnitude exceeds 2^(N-1)-1, the design SHALL set o_overflow=1 and saturate the quotient.
- Positive result saturates to 0x7FFF; negative result saturates to 0x8000.
- Exception: a negative magnitude of exactly 2^(N-1) gives 0x8000 with o_overflow=0.
REQ-020 Divisor equal to zero SHALL still take the full latency, then set o_overflow=1 and output the saturated value for the dividend's sign.
- Positive (or zero) dividend gives 0x7FFF; negative dividend gives 0x8000.
REQ-021 A zero dividend with a nonzero divisor SHALL give quotient 0 with o_overflow=0.
REQ-022 In IDLE and RUN, o_complete SHALL be 0; o_quotient_out holds its previous value.

Reset
REQ-023 Assertion of i_rst_n=0 SHALL immediately force:
- state to IDLE;
- o_quotient_out=0, o_complete=0, o_overflow=0;
- all internal registers to 0.
REQ-024 Reset during RUN SHALL abandon the division; no o_complete pulse follows.
REQ-025 After release, the first i_start behaves as in REQ-013.

Configuration
REQ-026 Macro QDIV_ROUND_EN, when defined, SHALL replace truncation with round-half-away-from-zero.
- Increment the magnitude when 2*remainder >= |divisor|, before the overflow check and sign application.
- Latency is unchanged.
- Without the macro, truncation per REQ-018 applies.

Structure
REQ-027 Package qdiv_pkg SHALL hold:
- default constants QDIV_N=16 and QDIV_Q=8;
- the FSM state typedef (IDLE, RUN, DONE);
- localparams for the saturation values.
REQ-028 The design SHALL be a single module with no sub-modules; a dedicated iteration counter sized clog2(N+Q) is required.

Verification
REQ-029 Dividend 0x0300 (3.0), divisor 0x0600 (6.0), start pulsed for one cycle -> within 24 cycles o_complete=1, o_quotient_out=0x0080, o_overflow=0.
REQ-030 Dividend 0xFD00 (-3.0), divisor 0x0600 -> o_quotient_out=0xFF80 (-0.5), o_overflow=0, and the value stays stable until the next start.
REQ-031 Dividend 0x7F00, divisor 0x0080 (0.5) -> o_overflow=1, o_quotient_out=0x7FFF; dividend 0x8100 with the same divisor -> 0x8000 with o_overflow=1.
REQ-032 Divisor 0x0000, dividend 0x0100 -> after 23 cycles o_complete=1, o_overflow=1, o_quotient_out=0x7FFF.
REQ-033 Reset asserted at cycle 10 of a division -> outputs 0 immediately; no o_complete afterwards; the next start with 0x0300/0x0600 yields 0x0080.
REQ-034 Start re-asserted at cycle 5 with new operands 0x0100/0x0400 -> exactly 23 cycles later o_quotient_out=0x0040 (0.25).
